// File: rtl/csr_commit_ctrl_pkg.sv
// rtl/csr_commit_ctrl_pkg.sv - shared encodings, CSR numbers and WB payload type for csr_commit_ctrl
package csr_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RD   = 2'd1,
    CSR_OP_WR   = 2'd2,
    CSR_OP_XCHG = 2'd3
  } csr_op_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [5:0] ECODE_INT = 6'h0;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_PRMD   = 14'h0001;
  localparam logic [13:0] CSR_ESTAT  = 14'h0005;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_EENTRY = 14'h000c;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;

  typedef struct packed {
    logic [31:0] pc;
    csr_op_t     csr_op;
    logic        ertn;
    logic [13:0] csr_num;
    logic [31:0] rd_val;
    logic [31:0] rj_val;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] vaddr;
  } ws_payload_t;

  // Idle payload: everything zero except the PC, which shows the reset vector.
  function automatic ws_payload_t ws_reset_value(input logic [31:0] reset_pc);
    ws_payload_t p;
    p    = '0;
    p.pc = reset_pc;
    return p;
  endfunction

endpackage

// File: rtl/csr_ws_reg.sv
// rtl/csr_ws_reg.sv - writeback-stage valid/payload register with load enable and discard
module csr_ws_reg
  import csr_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        discard,
  input  ws_payload_t in_payload,
  output logic        valid,
  output ws_payload_t payload
);

  // Valid lives for exactly one cycle per accepted, non-discarded instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else begin
      valid <= load & ~discard;
    end
  end

  // Payload holds its last committed contents so wb_pc stays meaningful between commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload <= ws_reset_value(RESET_PC);
    end else if (load && !discard) begin
      payload <= in_payload;
    end
  end

endmodule

// File: rtl/csr_commit_ctrl.sv
// rtl/csr_commit_ctrl.sv - WB-stage CSR access and exception commit with redirect handshake; optional CSR_COMMIT_INT_EN
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [1:0]  in_csr_op,
  input  logic        in_ertn,
  input  logic [13:0] in_csr_num,
  input  logic [31:0] in_rd_val,
  input  logic [31:0] in_rj_val,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_result,
  input  logic        in_ex,
  input  logic [5:0]  in_ecode,
  input  logic [8:0]  in_esubcode,
  input  logic [31:0] in_vaddr,
  output logic        csr_re,
  output logic [13:0] csr_rnum,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [13:0] csr_wnum,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        eret_flush,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush_valid,
  output logic [31:0] flush_target,
  input  logic        flush_ack
);

  state_t      state;
  state_t      state_n;
  logic        ws_valid;
  ws_payload_t ws;
  ws_payload_t in_payload;
  logic        int_req;
  logic        eff_ex;
  logic        take_int;
  logic        is_csr;
  logic        flush_cause;
  logic [31:0] flush_target_n;
  logic [31:0] flush_target_q;
  logic        discard;

`ifdef CSR_COMMIT_INT_EN
  assign int_req = has_int;
`else
  logic unused_has_int;
  assign unused_has_int = has_int;
  assign int_req        = 1'b0;
`endif

  assign in_ready = 1'b1;

  assign in_payload = '{
    pc:       in_pc,
    csr_op:   csr_op_t'(in_csr_op),
    ertn:     in_ertn,
    csr_num:  in_csr_num,
    rd_val:   in_rd_val,
    rj_val:   in_rj_val,
    dest:     in_dest,
    result:   in_result,
    ex:       in_ex,
    ecode:    in_ecode,
    esubcode: in_esubcode,
    vaddr:    in_vaddr
  };

  // Anything accepted while redirecting, or alongside a redirecting commit, is on the wrong path.
  assign discard = (state == ST_FLUSH) | flush_cause;

  csr_ws_reg #(
    .RESET_PC (RESET_PC)
  ) u_ws_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (in_valid & in_ready),
    .discard    (discard),
    .in_payload (in_payload),
    .valid      (ws_valid),
    .payload    (ws)
  );

  // An earlier-stage exception keeps its own tag; only a bare interrupt reports ECODE_INT.
  assign eff_ex   = ws.ex | int_req;
  assign take_int = int_req & ~ws.ex;
  assign is_csr   = (ws.csr_op != CSR_OP_NONE);

  assign csr_rnum     = ws.csr_num;
  assign csr_wnum     = ws.csr_num;
  assign csr_wmask    = (ws.csr_op == CSR_OP_WR) ? 32'hffffffff : ws.rj_val;
  assign csr_wvalue   = ws.rd_val;
  assign wb_ecode     = take_int ? ECODE_INT : ws.ecode;
  assign wb_esubcode  = take_int ? 9'h0 : ws.esubcode;
  assign wb_vaddr     = take_int ? 32'h0 : ws.vaddr;
  assign wb_pc        = ws.pc;
  assign rf_waddr     = ws.dest;
  assign rf_wdata     = is_csr ? csr_rvalue : ws.result;
  assign flush_valid  = (state == ST_FLUSH);
  assign flush_target = flush_target_q;

  // Commit decode (exception > ertn > CSR op) and the RUN/FLUSH next-state.
  always_comb begin
    csr_re         = 1'b0;
    csr_we         = 1'b0;
    wb_ex          = 1'b0;
    eret_flush     = 1'b0;
    rf_we          = 1'b0;
    flush_cause    = 1'b0;
    flush_target_n = flush_target_q;
    state_n        = state;

    if (ws_valid) begin
      if (eff_ex) begin
        wb_ex          = 1'b1;
        flush_cause    = 1'b1;
        flush_target_n = ex_entry;
      end else if (ws.ertn) begin
        eret_flush     = 1'b1;
        flush_cause    = 1'b1;
        flush_target_n = ertn_entry;
      end else begin
        rf_we = (ws.dest != 5'd0);
        if (is_csr) begin
          csr_re = 1'b1;
        end
        if (ws.csr_op == CSR_OP_WR || ws.csr_op == CSR_OP_XCHG) begin
          csr_we         = 1'b1;
          flush_cause    = 1'b1;
          flush_target_n = ws.pc + 32'd4;
        end
      end
    end

    case (state)
      ST_RUN:   if (flush_cause) state_n = ST_FLUSH;
      ST_FLUSH: if (flush_ack)   state_n = ST_RUN;
      default:  state_n = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_n;
    end
  end

  // Redirect target is captured once at the causing commit and held through FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_target_q <= RESET_PC;
    end else if (flush_cause) begin
      flush_target_q <= flush_target_n;
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// tb/tb_csr_commit_ctrl.sv - scoreboard bench for csr_commit_ctrl; follows CSR_COMMIT_INT_EN if defined
module tb_csr_commit_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h1c000000;
  localparam logic [31:0] EX_ENTRY   = 32'h1c008000;
  localparam logic [31:0] ERTN_ENTRY = 32'h1c000100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [1:0]  in_csr_op = '0;
  logic        in_ertn = 1'b0;
  logic [13:0] in_csr_num = '0;
  logic [31:0] in_rd_val = '0;
  logic [31:0] in_rj_val = '0;
  logic [4:0]  in_dest = '0;
  logic [31:0] in_result = '0;
  logic        in_ex = 1'b0;
  logic [5:0]  in_ecode = '0;
  logic [8:0]  in_esubcode = '0;
  logic [31:0] in_vaddr = '0;
  logic        csr_re;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        eret_flush;
  logic        has_int = 1'b0;
  logic [31:0] ex_entry = EX_ENTRY;
  logic [31:0] ertn_entry = ERTN_ENTRY;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush_valid;
  logic [31:0] flush_target;
  logic        flush_ack = 1'b0;

  always #5 clk = ~clk;

  // Static CSR contents seen by reads (old values).
  always_comb begin
    case (csr_rnum)
      14'h0001: csr_rvalue = 32'h00000007;
      14'h0030: csr_rvalue = 32'h0000000a;
      14'h0031: csr_rvalue = 32'h00000055;
      default:  csr_rvalue = 32'h0;
    endcase
  end

  csr_commit_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_csr_op(in_csr_op), .in_ertn(in_ertn), .in_csr_num(in_csr_num),
    .in_rd_val(in_rd_val), .in_rj_val(in_rj_val), .in_dest(in_dest), .in_result(in_result),
    .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode), .in_vaddr(in_vaddr),
    .csr_re(csr_re), .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wnum(csr_wnum), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .eret_flush(eret_flush), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush_valid(flush_valid), .flush_target(flush_target), .flush_ack(flush_ack)
  );

  typedef struct packed {
    logic        ex;
    logic        eret;
    logic        re;
    logic        we;
    logic        rfwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [13:0] num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] flush_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Commit monitor: pops one expectation per cycle that shows any commit strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (csr_re || csr_we || wb_ex || eret_flush || rf_we)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit actual pc=%h required=none", wb_pc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_ex", {31'b0, wb_ex}, {31'b0, e.ex});
        chk("eret_flush", {31'b0, eret_flush}, {31'b0, e.eret});
        chk("csr_re", {31'b0, csr_re}, {31'b0, e.re});
        chk("csr_we", {31'b0, csr_we}, {31'b0, e.we});
        chk("rf_we", {31'b0, rf_we}, {31'b0, e.rfwe});
        if (e.re) chk("csr_rnum", {18'b0, csr_rnum}, {18'b0, e.num});
        if (e.we) begin
          chk("csr_wnum", {18'b0, csr_wnum}, {18'b0, e.num});
          chk("csr_wmask", csr_wmask, e.wmask);
          chk("csr_wvalue", csr_wvalue, e.wvalue);
        end
        if (e.rfwe) begin
          chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.waddr});
          chk("rf_wdata", rf_wdata, e.wdata);
        end
        if (e.ex) begin
          chk("wb_ecode", {26'b0, wb_ecode}, {26'b0, e.ecode});
          chk("wb_esubcode", {23'b0, wb_esubcode}, {23'b0, e.esub});
          chk("wb_vaddr", wb_vaddr, e.vaddr);
          chk("wb_pc", wb_pc, e.pc);
        end
      end
    end
  end

  // Flush monitor: a new redirect pops its target; every FLUSH cycle must hold it.
  logic        fv_prev = 1'b0;
  logic        f_have  = 1'b0;
  logic [31:0] f_exp   = '0;
  always @(negedge clk) begin
    if (flush_valid) begin
      if (!fv_prev) begin
        if (flush_q.size() == 0) begin
          total++;
          bad++;
          f_have = 1'b0;
          $display("FAIL unexpected_flush actual target=%h required=none", flush_target);
        end else begin
          f_exp  = flush_q.pop_front();
          f_have = 1'b1;
        end
      end
      if (f_have) chk("flush_target", flush_target, f_exp);
    end
    fv_prev = flush_valid;
  end

  task automatic drive(input logic [31:0] pc, input logic [1:0] op, input logic ertn,
                       input logic [13:0] num, input logic [31:0] rd, input logic [31:0] rj,
                       input logic [4:0] dest, input logic [31:0] result, input logic ex,
                       input logic [5:0] ecode, input logic [31:0] vaddr);
    in_pc = pc; in_csr_op = op; in_ertn = ertn; in_csr_num = num;
    in_rd_val = rd; in_rj_val = rj; in_dest = dest; in_result = result;
    in_ex = ex; in_ecode = ecode; in_esubcode = 9'h0; in_vaddr = vaddr;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [1:0] op, input logic ertn,
                       input logic [13:0] num, input logic [31:0] rd, input logic [31:0] rj,
                       input logic [4:0] dest, input logic [31:0] result, input logic ex,
                       input logic [5:0] ecode, input logic [31:0] vaddr);
    drive(pc, op, ertn, num, rd, rj, dest, result, ex, ecode, vaddr);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for FLUSH, holds it for 'hold' cycles (optionally feeding wrong-path input), then acks.
  task automatic flush_handshake(input int hold, input logic feed);
    int waitc;
    int cnt;
    waitc = 0;
    while (!flush_valid && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!flush_valid) begin
      total++;
      bad++;
      $display("FAIL flush_start actual=timeout required=flush_valid");
      return;
    end
    if (feed) drive(32'h1c0000f0, 2'd0, 1'b0, 14'h0, 32'h0, 32'h0, 5'd6, 32'h0000bad0, 1'b0, 6'h0, 32'h0);
    cnt = 1;
    repeat (hold - 1) begin
      @(negedge clk);
      if (flush_valid) cnt++;
    end
    flush_ack = 1'b1;
    @(negedge clk);
    flush_ack = 1'b0;
    in_valid  = 1'b0;
    chk("flush_len", cnt, hold);
    chk("flush_released", {31'b0, flush_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    @(negedge clk);
    chk("rst_flush_valid", {31'b0, flush_valid}, 32'd0);
    chk("rst_strobes", {27'b0, csr_re, csr_we, wb_ex, eret_flush, rf_we}, 32'd0);
    chk("rst_flush_target", flush_target, RESET_PC);
    chk("rst_wb_pc", wb_pc, RESET_PC);
    chk("rst_rf_wdata", rf_wdata, 32'h0);
    chk("rst_csr_wmask", csr_wmask, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // CSRRD: read old value into rd, no redirect.
    e = '0; e.re = 1; e.num = 14'h0001; e.rfwe = 1; e.waddr = 5'd3; e.wdata = 32'h7;
    exp_q.push_back(e);
    issue(32'h1c000000, 2'd1, 1'b0, 14'h0001, 32'h0, 32'h0, 5'd3, 32'h0, 1'b0, 6'h0, 32'h0);

    // CSRWR SAVE0: full mask, old value to rd, redirect to pc+4.
    e = '0; e.re = 1; e.we = 1; e.num = 14'h0030; e.wmask = 32'hffffffff; e.wvalue = 32'h12345678;
    e.rfwe = 1; e.waddr = 5'd4; e.wdata = 32'ha;
    exp_q.push_back(e);
    flush_q.push_back(32'h1c000014);
    issue(32'h1c000010, 2'd2, 1'b0, 14'h0030, 32'h12345678, 32'h0, 5'd4, 32'h0, 1'b0, 6'h0, 32'h0);
    flush_handshake(2, 1'b0);

    // CSRXCHG: rj is the write mask.
    e = '0; e.re = 1; e.we = 1; e.num = 14'h0031; e.wmask = 32'h0000ff00; e.wvalue = 32'haabbccdd;
    e.rfwe = 1; e.waddr = 5'd5; e.wdata = 32'h55;
    exp_q.push_back(e);
    flush_q.push_back(32'h1c000024);
    issue(32'h1c000020, 2'd3, 1'b0, 14'h0031, 32'haabbccdd, 32'h0000ff00, 5'd5, 32'h0, 1'b0, 6'h0, 32'h0);
    flush_handshake(1, 1'b0);

    // ALE exception on a CSRWR: no CSR/rf write; next instruction accepted at commit is dropped.
    e = '0; e.ex = 1; e.ecode = 6'h9; e.esub = 9'h0; e.vaddr = 32'h1003; e.pc = 32'h1c000030;
    exp_q.push_back(e);
    flush_q.push_back(EX_ENTRY);
    issue(32'h1c000030, 2'd2, 1'b0, 14'h0030, 32'h1, 32'h0, 5'd7, 32'h0, 1'b1, 6'h9, 32'h1003);
    drive(32'h1c000034, 2'd0, 1'b0, 14'h0, 32'h0, 32'h0, 5'd8, 32'h0000dead, 1'b0, 6'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    flush_handshake(2, 1'b0);

    // ertn: one-cycle eret_flush, FLUSH held 3 cycles with wrong-path input discarded.
    e = '0; e.eret = 1;
    exp_q.push_back(e);
    flush_q.push_back(ERTN_ENTRY);
    issue(32'h1c000040, 2'd0, 1'b1, 14'h0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 6'h0, 32'h0);
    flush_handshake(3, 1'b1);

    // Pending interrupt at a NONE commit.
    e = '0;
`ifdef CSR_COMMIT_INT_EN
    e.ex = 1; e.ecode = 6'h0; e.esub = 9'h0; e.vaddr = 32'h0; e.pc = 32'h1c000050;
    flush_q.push_back(EX_ENTRY);
`else
    e.rfwe = 1; e.waddr = 5'd9; e.wdata = 32'h00001111;
`endif
    exp_q.push_back(e);
    has_int = 1'b1;
    issue(32'h1c000050, 2'd0, 1'b0, 14'h0, 32'h0, 32'h0, 5'd9, 32'h00001111, 1'b0, 6'h3f, 32'hffff);
    @(negedge clk);
    has_int = 1'b0;
`ifdef CSR_COMMIT_INT_EN
    flush_handshake(1, 1'b0);
`endif

    // Reset in the middle of FLUSH, then a normal commit.
    e = '0; e.re = 1; e.we = 1; e.num = 14'h0030; e.wmask = 32'hffffffff; e.wvalue = 32'h1;
    exp_q.push_back(e);
    flush_q.push_back(32'h1c000064);
    issue(32'h1c000060, 2'd2, 1'b0, 14'h0030, 32'h1, 32'h0, 5'd0, 32'h0, 1'b0, 6'h0, 32'h0);
    @(negedge clk);
    chk("pre_rst_flush_valid", {31'b0, flush_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst_flush_valid", {31'b0, flush_valid}, 32'd0);
    chk("async_rst_flush_target", flush_target, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
    e = '0; e.rfwe = 1; e.waddr = 5'd10; e.wdata = 32'h00002222;
    exp_q.push_back(e);
    issue(32'h1c000070, 2'd0, 1'b0, 14'h0, 32'h0, 32'h0, 5'd10, 32'h00002222, 1'b0, 6'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_no_flush", {31'b0, flush_valid}, 32'd0);

    repeat (4) @(negedge clk);
    chk("commit_queue_drained", exp_q.size(), 32'd0);
    chk("flush_queue_drained", flush_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
